// File: rtl/sobel_window_gen.sv
// sobel_window_gen: turns a raster 8-bit pixel stream into registered 3x3
// windows (data_r_c_o), centre coords (cnt_row_o/cnt_col_o), core_en_o and
// a frame_done_o pulse. Inputs: clk, rst (async, active-high), pixel_i,
// pixel_valid_i. Two line buffers hold the previous two rows.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_i,
    input  logic       pixel_valid_i,
    output logic [7:0] data_0_0_o,
    output logic [7:0] data_0_1_o,
    output logic [7:0] data_0_2_o,
    output logic [7:0] data_1_0_o,
    output logic [7:0] data_1_1_o,
    output logic [7:0] data_1_2_o,
    output logic [7:0] data_2_0_o,
    output logic [7:0] data_2_1_o,
    output logic [7:0] data_2_2_o,
    output logic       core_en_o,
    output logic [9:0] cnt_col_o,
    output logic [9:0] cnt_row_o,
    output logic       frame_done_o
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [9:0] COL_LAST = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_HEIGHT - 1);

    logic [9:0]    in_col;
    logic [9:0]    in_row;
    logic [AW-1:0] addr;
    logic [7:0]    lb0 [0:IMG_WIDTH-1];
    logic [7:0]    lb1 [0:IMG_WIDTH-1];
    logic [7:0]    top;
    logic [7:0]    mid;
    logic [7:0]    win  [3][3];
    logic [7:0]    nwin [3][3];
    logic [7:0]    dout [3][3];
    logic          col_last;
    logic          row_last;
    logic          complete;

    assign addr     = in_col[AW-1:0];
    assign top      = lb0[addr];
    assign mid      = lb1[addr];
    assign col_last = (in_col == COL_LAST);
    assign row_last = (in_row == ROW_LAST);

    // Only windows whose three columns all belong to the current row are
    // emitted; in_col<2 still carries columns from the previous row.
    assign complete = pixel_valid_i
                    && (in_row >= 10'd2)
                    && (in_col >= 10'd2);

    // Window after this accept: shift left, new right column enters.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nwin[r][0] = win[r][1];
            nwin[r][1] = win[r][2];
            nwin[r][2] = win[r][2];
        end
        nwin[0][2] = top;
        nwin[1][2] = mid;
        nwin[2][2] = pixel_i;
    end

    // Line buffers carry no reset; every location is rewritten before a
    // window that depends on it can be emitted.
    always_ff @(posedge clk) begin
        if (pixel_valid_i) begin
            lb0[addr] <= mid;
            lb1[addr] <= pixel_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_col       <= '0;
            in_row       <= '0;
            core_en_o    <= 1'b0;
            frame_done_o <= 1'b0;
            cnt_col_o    <= '0;
            cnt_row_o    <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c]  <= '0;
                    dout[r][c] <= '0;
                end
            end
        end else begin
            core_en_o    <= complete;
            frame_done_o <= pixel_valid_i && col_last && row_last;
            if (pixel_valid_i) begin
                win <= nwin;
                if (col_last) begin
                    in_col <= '0;
                    in_row <= row_last ? 10'd0 : in_row + 10'd1;
                end else begin
                    in_col <= in_col + 10'd1;
                end
            end
            if (complete) begin
                dout      <= nwin;
                cnt_col_o <= in_col - 10'd1;
                cnt_row_o <= in_row - 10'd1;
            end
        end
    end

    assign data_0_0_o = dout[0][0];
    assign data_0_1_o = dout[0][1];
    assign data_0_2_o = dout[0][2];
    assign data_1_0_o = dout[1][0];
    assign data_1_1_o = dout[1][1];
    assign data_1_2_o = dout[1][2];
    assign data_2_0_o = dout[2][0];
    assign data_2_1_o = dout[2][1];
    assign data_2_2_o = dout[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: four instances (4x4, 8x6, 3x3,
// 1024x3) share clk/rst; one is selected at a time for stimulus.
module tb_sobel_window_gen;

    function automatic int wof(int k);
        return (k == 0) ? 4 : (k == 1) ? 8 : (k == 2) ? 3 : 1024;
    endfunction
    function automatic int hof(int k);
        return (k == 0) ? 4 : (k == 1) ? 6 : 3;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix = '0;
    logic       vld = 1'b0;
    logic [1:0] sel = '0;

    logic [7:0] dq  [4][9];
    logic       en  [4];
    logic       fd  [4];
    logic [9:0] col [4];
    logic [9:0] row [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sobel_window_gen #(
            .IMG_WIDTH (wof(g)),
            .IMG_HEIGHT(hof(g))
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .pixel_i      (pix),
            .pixel_valid_i(vld && (sel == 2'(g))),
            .data_0_0_o   (dq[g][0]),
            .data_0_1_o   (dq[g][1]),
            .data_0_2_o   (dq[g][2]),
            .data_1_0_o   (dq[g][3]),
            .data_1_1_o   (dq[g][4]),
            .data_1_2_o   (dq[g][5]),
            .data_2_0_o   (dq[g][6]),
            .data_2_1_o   (dq[g][7]),
            .data_2_2_o   (dq[g][8]),
            .core_en_o    (en[g]),
            .cnt_col_o    (col[g]),
            .cnt_row_o    (row[g]),
            .frame_done_o (fd[g])
        );
    end

    logic [71:0] owin;
    always_comb begin
        owin = '0;
        for (int k = 0; k < 9; k++) owin[71-8*k -: 8] = dq[sel][k];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  img [0:5][0:1023];
    int          mr, mc, mW, mH;
    logic        exp_en, exp_fd;
    logic [9:0]  erow, ecol;
    logic [71:0] ewin;
    int          pulses;
    // Observed capture
    int          dut_pulses;
    logic [71:0] first_win, last_win;
    logic [9:0]  first_row, first_col, last_row, last_col;
    logic        last_fd;

    task automatic chk(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] s);
        sel = s;
        mW = wof(int'(s));
        mH = hof(int'(s));
        mr = 0;
        mc = 0;
        pulses = 0;
        dut_pulses = 0;
        erow = '0;
        ecol = '0;
        ewin = '0;
    endtask

    task automatic push(input logic [7:0] p, input logic v);
        pix = p;
        vld = v;
        @(posedge clk);
        #1;
        exp_en = 1'b0;
        exp_fd = 1'b0;
        if (v) begin
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                exp_en = 1'b1;
                erow = 10'(mr - 1);
                ecol = 10'(mc - 1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ewin[71-8*(3*i+j) -: 8] = img[mr-2+i][mc-2+j];
                pulses++;
            end
            if (mr == mH - 1 && mc == mW - 1) exp_fd = 1'b1;
            if (mc == mW - 1) begin
                mc = 0;
                mr = (mr == mH - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        chk("core_en", 80'(en[sel]), 80'(exp_en));
        chk("frame_done", 80'(fd[sel]), 80'(exp_fd));
        chk("cnt_row", 80'(row[sel]), 80'(erow));
        chk("cnt_col", 80'(col[sel]), 80'(ecol));
        chk("window", 80'(owin), 80'(ewin));
        if (en[sel]) begin
            if (dut_pulses == 0) begin
                first_win = owin;
                first_row = row[sel];
                first_col = col[sel];
            end
            dut_pulses++;
            last_win = owin;
            last_row = row[sel];
            last_col = col[sel];
            last_fd  = fd[sel];
        end
        vld = 1'b0;
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_en"}, 80'(en[sel]), 80'(0));
        chk({tag, "_fd"}, 80'(fd[sel]), 80'(0));
        chk({tag, "_row"}, 80'(row[sel]), 80'(0));
        chk({tag, "_col"}, 80'(col[sel]), 80'(0));
        chk({tag, "_win"}, 80'(owin), 80'(0));
    endtask

    initial begin
        start(2'd0);
        #2;
        zero_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // 4x4, pixel = 16*row+col, valid every cycle
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) push(8'(16*r + c), 1'b1);
        chk("p4_pulses", 80'(dut_pulses), 80'(4));
        chk("p4_first_win", 80'(first_win), 80'(72'h000102101112202122));
        chk("p4_first_rc", 80'({first_row, first_col}), 80'({10'd1, 10'd1}));
        chk("p4_last_d22", 80'(last_win[7:0]), 80'(8'h33));
        chk("p4_last_rc", 80'({last_row, last_col}), 80'({10'd2, 10'd2}));
        chk("p4_last_fd", 80'(last_fd), 80'(1));

        // Same image with valid toggled 1,0,0
        start(2'd0);
        erow = 10'd2; ecol = 10'd2; ewin = last_win;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                push(8'(16*r + c), 1'b1);
                push(8'hEE, 1'b0);
                push(8'hDD, 1'b0);
            end
        chk("gap_pulses", 80'(dut_pulses), 80'(4));
        chk("gap_first_win", 80'(first_win), 80'(72'h000102101112202122));

        // Asynchronous reset mid-clock during row 3
        start(2'd0);
        erow = 10'd2; ecol = 10'd2; ewin = last_win;
        for (int k = 0; k < 13; k++) push(8'(16*(k/4) + k%4), 1'b1);
        chk("pre_rst_en_seen", 80'(dut_pulses), 80'(2));
        #2 rst = 1'b1;
        #1;
        zero_outputs("async_rst");
        #3 rst = 1'b0;
        start(2'd0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) push(8'(8'h80 + 16*r + c), 1'b1);
        chk("post_rst_pulses", 80'(dut_pulses), 80'(4));
        chk("post_rst_first_rc", 80'({first_row, first_col}),
            80'({10'd1, 10'd1}));
        chk("post_rst_first_win", 80'(first_win),
            80'(72'h808182909192a0a1a2));

        // 8x6 random, two frames back to back
        for (int f = 0; f < 2; f++) begin
            start(2'd1);
            if (f == 1) begin
                erow = 10'd4; ecol = 10'd6; ewin = last_win;
            end
            for (int k = 0; k < 48; k++) push(8'($urandom_range(0, 255)), 1'b1);
            chk("rand_pulses", 80'(dut_pulses), 80'(24));
            chk("rand_first_rc", 80'({first_row, first_col}),
                80'({10'd1, 10'd1}));
            chk("rand_last_fd", 80'(last_fd), 80'(1));
        end

        // 3x3 all-255
        start(2'd2);
        for (int k = 0; k < 9; k++) push(8'hFF, 1'b1);
        chk("w3_pulses", 80'(dut_pulses), 80'(1));
        chk("w3_win", 80'(last_win), 80'({9{8'hFF}}));
        chk("w3_rc", 80'({last_row, last_col}), 80'({10'd1, 10'd1}));
        chk("w3_fd", 80'(last_fd), 80'(1));

        // 1024x3, no 10-bit overflow
        start(2'd3);
        for (int k = 0; k < 3072; k++) push(8'(k % 251), 1'b1);
        chk("w1024_pulses", 80'(dut_pulses), 80'(1022));
        chk("w1024_first_col", 80'(first_col), 80'(1));
        chk("w1024_last_rc", 80'({last_row, last_col}),
            80'({10'd1, 10'd1022}));
        chk("w1024_fd", 80'(last_fd), 80'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
